clk_div_bank: RTL

Multi-channel, runtime-programmable clock-enable/divided-clock generator; the parametrised successor of the fixed single-output divider. It produces CHANNELS independent divided outputs from the system clock. Each channel has its own divisor, its own mode (50 % toggle or single-cycle tick) and its own enable. Divisors are reprogrammed through a valid/ready port with glitch-free changeover at the channel's terminal count. It sits beside the top-level clock, feeding display scan, debounce and 1 Hz timekeeping logic.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 104 ++++++++++
 rtl/clk_div_bank.sv | 54 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider bank.
package clk_div_pkg;

   localparam logic        MODE_TOGGLE   = 1'b0;
   localparam logic        MODE_PULSE    = 1'b1;
   localparam int unsigned DEFAULT_WIDTH = 32;

   // Width of a channel index; never less than one bit so a single-channel bank still has a port.
   function automatic int unsigned ch_idx_width(input int unsigned channels);
      if (channels <= 2) begin
         return 1;
      end
      return $clog2(channels);
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor/mode, pending flag and terminal-count commit.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned WIDTH       = DEFAULT_WIDTH,
   parameter int unsigned DEFAULT_DIV = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_div,
   input  logic             wr_mode,
   output logic             pending,
   output logic             tick,
   output logic             clk_out
);

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] sdiv_q, sdiv_d;
   logic             mode_q, mode_d;
   logic             smode_q, smode_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;

   logic stalled;
   logic tc;
   logic commit;

   assign stalled = !en || (div_q == '0);
   assign tc      = !stalled && (cnt_q == div_q - WIDTH'(1));
   // An idle channel has no terminal count to wait for, so it takes the update straight away.
   assign commit  = pend_q && (tc || stalled);

   always_comb begin
      cnt_d     = cnt_q;
      div_d     = div_q;
      sdiv_d    = sdiv_q;
      mode_d    = mode_q;
      smode_d   = smode_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;

      if (stalled) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (tc) begin
         cnt_d     = '0;
         tick_d    = 1'b1;
         clk_out_d = (mode_q == MODE_TOGGLE) ? !clk_out_q : 1'b1;
      end else begin
         cnt_d     = cnt_q + WIDTH'(1);
         clk_out_d = (mode_q == MODE_TOGGLE) ? clk_out_q : 1'b0;
      end

      if (commit) begin
         div_d  = sdiv_q;
         mode_d = smode_q;
         pend_d = 1'b0;
         if ((mode_q == MODE_TOGGLE) && (smode_q == MODE_PULSE)) begin
            clk_out_d = 1'b0;
         end
      end

      // A write on the TC edge lands in the shadow only; commit above used the old pending flag.
      if (wr_en) begin
         sdiv_d  = wr_div;
         smode_d = wr_mode;
         pend_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         div_q     <= RST_DIV;
         sdiv_q    <= RST_DIV;
         mode_q    <= MODE_TOGGLE;
         smode_q   <= MODE_TOGGLE;
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         sdiv_q    <= sdiv_d;
         mode_q    <= mode_d;
         smode_q   <= smode_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign pending = pend_q;
   assign tick    = tick_q;
   assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable dividers sharing one valid/ready configuration port.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int unsigned WIDTH       = DEFAULT_WIDTH,
   parameter  int unsigned CHANNELS    = 4,
   parameter  int unsigned DEFAULT_DIV = 50_000_000,
   localparam int unsigned CW          = ch_idx_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] en,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   input  logic                cfg_mode
);

   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] wr_sel;

   // Out-of-range channel numbers match nothing, so they are accepted and dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (cfg_ch == CW'(i)) begin
            cfg_ready = !pending[i];
         end
      end
   end

   for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_chan
      assign wr_sel[gi] = cfg_valid && cfg_ready && (cfg_ch == CW'(gi));

      clk_div_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en[gi]),
         .wr_en   (wr_sel[gi]),
         .wr_div  (cfg_div),
         .wr_mode (cfg_mode),
         .pending (pending[gi]),
         .tick    (tick[gi]),
         .clk_out (clk_out[gi])
      );
   end

endmodule
